// File: rtl/jamma_input_scanner.sv
`default_nettype none
// ============================================================================
// jamma_input_scanner : time-multiplexed JAMMA P1/P2/coin scanner with
//                       per-bit debounce and on-board joystick merge.
// Revision 1.0
// ============================================================================
module jamma_input_scanner #(
    parameter int SETTLE = 3,
    parameter int DEB_N  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] jjoy,
    input  logic [1:0] jcoin,
    input  logic [5:0] kbd_joy,
    output logic       jselect,
    output logic [7:0] joystick1,
    output logic [7:0] joystick2,
    output logic [1:0] coin,
    output logic       scan_done
);

    localparam int             CW            = (SETTLE > 2) ? $clog2(SETTLE) : 2;
    localparam logic [CW-1:0]  SETTLE_RELOAD = CW'(SETTLE - 1);
    localparam logic [3:0]     DEB_LIMIT     = 4'(DEB_N);

    localparam logic [1:0] P1_SETTLE = 2'd0;
    localparam logic [1:0] P1_SAMPLE = 2'd1;
    localparam logic [1:0] P2_SETTLE = 2'd2;
    localparam logic [1:0] P2_SAMPLE = 2'd3;

    logic [7:0]    jjoy_meta_q, jjoy_meta_d, jjoy_sync_q, jjoy_sync_d;
    logic [1:0]    jcoin_meta_q, jcoin_meta_d, jcoin_sync_q, jcoin_sync_d;
    logic [5:0]    kbd_meta_q, kbd_meta_d, kbd_sync_q, kbd_sync_d;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          jselect_q, jselect_d;
    logic          scan_done_q, scan_done_d;
    logic [17:0]   sample_vec, sample_en, stable_vec;

    always_comb begin
        jjoy_meta_d  = jjoy;
        jjoy_sync_d  = jjoy_meta_q;
        jcoin_meta_d = jcoin;
        jcoin_sync_d = jcoin_meta_q;
        kbd_meta_d   = kbd_joy;
        kbd_sync_d   = kbd_meta_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            jjoy_meta_q  <= '1;
            jjoy_sync_q  <= '1;
            jcoin_meta_q <= '1;
            jcoin_sync_q <= '1;
            kbd_meta_q   <= '1;
            kbd_sync_q   <= '1;
        end else begin
            jjoy_meta_q  <= jjoy_meta_d;
            jjoy_sync_q  <= jjoy_sync_d;
            jcoin_meta_q <= jcoin_meta_d;
            jcoin_sync_q <= jcoin_sync_d;
            kbd_meta_q   <= kbd_meta_d;
            kbd_sync_q   <= kbd_sync_d;
        end
    end

    // jselect only moves on entry to a settle phase, so the mux has the
    // whole settle window to propagate through the synchroniser.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        jselect_d   = jselect_q;
        scan_done_d = 1'b0;
        case (state_q)
            P1_SETTLE: begin
                if (cnt_q == '0) state_d = P1_SAMPLE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            P1_SAMPLE: begin
                state_d   = P2_SETTLE;
                cnt_d     = SETTLE_RELOAD;
                jselect_d = 1'b1;
            end
            P2_SETTLE: begin
                if (cnt_q == '0) state_d = P2_SAMPLE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            P2_SAMPLE: begin
                state_d     = P1_SETTLE;
                cnt_d       = SETTLE_RELOAD;
                jselect_d   = 1'b0;
                scan_done_d = 1'b1;
            end
            default: begin
                state_d   = P1_SETTLE;
                cnt_d     = SETTLE_RELOAD;
                jselect_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= P1_SETTLE;
            cnt_q       <= SETTLE_RELOAD;
            jselect_q   <= 1'b0;
            scan_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            jselect_q   <= jselect_d;
            scan_done_q <= scan_done_d;
        end
    end

    // Bit map: [7:0] player 1, [15:8] player 2, [17:16] coins.
    assign sample_vec = {jcoin_sync_q, jjoy_sync_q, jjoy_sync_q};
    assign sample_en  = {{10{state_q == P2_SAMPLE}}, {8{state_q == P1_SAMPLE}}};

    for (genvar i = 0; i < 18; i++) begin : g_deb
        logic [3:0] deb_cnt_q, deb_cnt_d, deb_inc;
        logic       stable_q, stable_d;

        always_comb begin
            deb_cnt_d = deb_cnt_q;
            stable_d  = stable_q;
            deb_inc   = deb_cnt_q + 4'd1;
            if (sample_en[i]) begin
                if (sample_vec[i] == stable_q) begin
                    deb_cnt_d = '0;
                end else if (deb_inc == DEB_LIMIT) begin
                    stable_d  = sample_vec[i];
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_inc;
                end
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                deb_cnt_q <= '0;
                stable_q  <= 1'b1;
            end else begin
                deb_cnt_q <= deb_cnt_d;
                stable_q  <= stable_d;
            end
        end

        assign stable_vec[i] = stable_q;
    end

    assign jselect   = jselect_q;
    assign scan_done = scan_done_q;
    assign joystick1 = {stable_vec[7:6], stable_vec[5:0] & kbd_sync_q};
    assign joystick2 = stable_vec[15:8];
    assign coin      = stable_vec[17:16];

endmodule
`default_nettype wire

// File: doc/jamma_input_scanner.md
Name: jamma_input_scanner

Overview:
- Time-multiplexed scanner for the JAMMA edge connector.
- Drives the external player-select line (JSELECT) and waits for the external mux to settle. It then samples the shared 8-bit JJOY bus once per player, plus the coin inputs, and debounces every bit.
- Outputs clean active-low joystick1/joystick2/coin buses straight to the PACMAN core's I_JOYSTICK_A/B, I_PLAYER and I_COIN inputs.
- Also merges the 6-bit on-board joystick into player 1.

Parameters:
SETTLE, 3, cycles per phase spent waiting after JSELECT changes before sampling; must be >= 3 (2-FF synchroniser plus 1 mux cycle).
DEB_N, 3, consecutive per-player samples at a new level required before a debounced bit changes; 1..15.

Ports:
clk  input  1  system clock (pclk domain)
reset  input  1  asynchronous, active-high reset
jjoy  input  8  raw JAMMA joystick/buttons bus, active-low, shared by both players
jcoin  input  2  raw coin switches, active-low
kbd_joy  input  6  on-board joystick, active-low, asynchronous
jselect  output  1  external mux select: 0 = player 1, 1 = player 2 (registered)
joystick1  output  8  debounced player 1, active-low; [5:0] ANDed with kbd_joy
joystick2  output  8  debounced player 2, active-low
coin  output  2  debounced coins, active-low
scan_done  output  1  one-cycle pulse once a full P1+P2 round has been committed

Behaviour:
- Reset (async, active-high) sets:
  - jselect=0, scan_done=0, joystick1=joystick2=8'hFF, coin=2'b11.
  - Synchronisers to all-ones, all debounce counters 0, FSM to P1_SETTLE with the settle counter loaded with SETTLE-1.
- Synchronisation: jjoy, jcoin and kbd_joy each pass through a 2-FF synchroniser; all logic uses the synchronised values.
- FSM states are P1_SETTLE, P1_SAMPLE, P2_SETTLE, P2_SAMPLE.
  - P1_SETTLE: jselect=0; counter decrements each cycle; at 0 go to P1_SAMPLE.
  - P1_SAMPLE (1 cycle): apply jjoy_sync to the player-1 debouncer; go to P2_SETTLE and reload the counter to SETTLE-1.
  - P2_SETTLE: jselect=1; same counting; at 0 go to P2_SAMPLE.
  - P2_SAMPLE (1 cycle): apply jjoy_sync to the player-2 debouncer and jcoin_sync to the coin debouncer; go to P1_SETTLE with the counter reloaded.
- jselect is a register. It changes on the clock edge that enters a SETTLE state, never during a SETTLE or SAMPLE state.
- Round length is 2*(SETTLE+1) cycles (8 at default). There is no wait or stall.
- Debounce, per bit, for 18 bits:
  - Each bit has a stable value and a 4-bit counter.
  - On a sample event for its group, if sample == stable, the counter clears.
  - Otherwise the counter increments. When it would reach DEB_N, stable takes the sample and the counter clears.
  - With DEB_N=1 a bit follows each sample.
  - Outside its group's sample cycle a bit holds.
- Outputs:
  - joystick1 = {stable_p1[7:6], stable_p1[5:0] & kbd_sync}, combinational AND of registers. A kbd_joy change is visible 2 cycles after the pin changes (synchroniser).
  - joystick2 = stable_p2; coin = stable_coin.
- scan_done is registered high for exactly the cycle after P2_SAMPLE; the new joystick2/coin values are already visible in that cycle.
- Boundary conditions:
  - A glitch shorter than DEB_N samples never reaches the outputs.
  - An alternating input never changes the output.
  - Simultaneous changes on several bits debounce independently.
  - Reset asserted mid-round aborts the round immediately. The round restarts from P1_SETTLE after release, with no scan_done pulse.

Test Plan:
- Reset release, all inputs 1 -> jselect=0 in cycles 0..3, 1 in cycles 4..7, 0 at cycle 8; scan_done high only at cycles 8, 16, 24; all outputs stay 0xFF / 2'b11.
- jjoy[0]=0 held from cycle 0 while jselect=0, 1 while jselect=1 -> joystick1[0]=0 from cycle 20 (after P1_SAMPLE at 19); joystick2 stays 0xFF.
- jjoy[4]=0 for exactly the P1 window of one round only -> joystick1 stays 0xFF throughout.
- jcoin=2'b10 held from cycle 0 -> coin=2'b10 from cycle 24 (after the third P2_SAMPLE at 23), coincident with the scan_done pulse.
- kbd_joy[2]=0 pulse of 1 cycle at cycle 40, all jjoy=1 -> joystick1[2]=0 for exactly 1 cycle at cycle 42; bits [7:6] unaffected.
- Player-2 debounce at 14/15 counts (DEB_N=15) then reset pulse in a P2_SETTLE phase -> outputs 0xFF, jselect=0 asynchronously; after release, 15 fresh P2 samples are needed before joystick2 changes.
